sram_controller: RTL

Memory-stage controller that turns the ALU's LDR/STR effective address into 32-bit word accesses on an external 16-bit asynchronous SRAM. Each word takes two half-word phases, low then high. The block sits directly downstream of the ALU: its address is the ALU result, and its `ready` output freezes the pipeline until the access completes. It is used by the MEM stage in place of a single-cycle data memory.

---
 rtl/sram_controller_pkg.sv | 20 ++
 rtl/sram_controller.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/sram_controller_pkg.sv
// Shared types and constants for the two-phase 16-bit SRAM controller.
package sram_controller_pkg;

  localparam int unsigned SramAddrW = 18;
  localparam int unsigned SramDataW = 16;

  typedef enum logic [1:0] {
    StIdle,
    StLo,
    StHi,
    StDone
  } state_e;

  // SRAM word index: (addr - base)[18:2], wrapping on underflow and truncating above bit 18.
  function automatic logic [SramAddrW-2:0] word_index(input logic [31:0] addr,
                                                      input logic [31:0] base);
    return (SramAddrW - 1)'((addr - base) >> 2);
  endfunction

endpackage

// File: rtl/sram_controller.sv
// MEM-stage controller: one 32-bit LDR/STR becomes two 16-bit asynchronous SRAM phases
// (low half then high half) while ready holds the pipeline.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int unsigned PHASE_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR    = 32'd1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rd_en,
  input  logic                 wr_en,
  input  logic [31:0]          address,
  input  logic [31:0]          write_data,
  output logic [31:0]          read_data,
  output logic                 ready,
  output logic [SramAddrW-1:0] sram_addr,
  output logic [SramDataW-1:0] sram_dq_out,
  output logic                 sram_dq_oe,
  input  logic [SramDataW-1:0] sram_dq_in,
  output logic                 sram_we_n,
  output logic                 sram_oe_n
);

  localparam int unsigned      CntW    = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [CntW-1:0]  CntLast = CntW'(PHASE_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   is_wr_q, is_wr_d;
  logic [SramAddrW-2:0]   word_q, word_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [31:0]            read_data_q, read_data_d;
  logic [SramAddrW-1:0]   sram_addr_q, sram_addr_d;
  logic [SramDataW-1:0]   dq_out_q, dq_out_d;
  logic                   dq_oe_q, dq_oe_d;
  logic                   we_n_q, we_n_d;
  logic                   oe_n_q, oe_n_d;
  logic                   cnt_last;
  logic                   in_phase_d;

  // Next-state, capture of the request, and the pad values for the upcoming cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_wr_d     = is_wr_q;
    word_d      = word_q;
    wdata_d     = wdata_q;
    read_data_d = read_data_q;
    sram_addr_d = sram_addr_q;
    dq_out_d    = dq_out_q;
    dq_oe_d     = 1'b0;
    we_n_d      = 1'b1;
    oe_n_d      = 1'b1;
    cnt_last    = (cnt_q == CntLast);

    unique case (state_q)
      StIdle: begin
        if (wr_en || rd_en) begin
          state_d = StLo;
          cnt_d   = '0;
          is_wr_d = wr_en;  // write wins when both are requested
          word_d  = word_index(address, BASE_ADDR);
          wdata_d = write_data;
        end
      end
      StLo: begin
        if (cnt_last) begin
          state_d = StHi;
          cnt_d   = '0;
          if (!is_wr_q) read_data_d[15:0] = sram_dq_in;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StHi: begin
        if (cnt_last) begin
          state_d = StDone;
          cnt_d   = '0;
          if (!is_wr_q) read_data_d[31:16] = sram_dq_in;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Pad outputs are registered, so they are derived from the state being entered.
    in_phase_d = (state_d == StLo) || (state_d == StHi);
    if (in_phase_d) begin
      sram_addr_d = {word_d, state_d == StHi};
      if (is_wr_d) begin
        dq_oe_d  = 1'b1;
        dq_out_d = (state_d == StHi) ? wdata_d[31:16] : wdata_d[15:0];
        // Strobe released on the last phase cycle so address/data are stable at its rising edge.
        we_n_d   = (cnt_d == CntLast);
      end else begin
        oe_n_d = 1'b0;
      end
    end
  end

  // State and registered outputs, with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      is_wr_q     <= 1'b0;
      word_q      <= '0;
      wdata_q     <= '0;
      read_data_q <= '0;
      sram_addr_q <= '0;
      dq_out_q    <= '0;
      dq_oe_q     <= 1'b0;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_wr_q     <= is_wr_d;
      word_q      <= word_d;
      wdata_q     <= wdata_d;
      read_data_q <= read_data_d;
      sram_addr_q <= sram_addr_d;
      dq_out_q    <= dq_out_d;
      dq_oe_q     <= dq_oe_d;
      we_n_q      <= we_n_d;
      oe_n_q      <= oe_n_d;
    end
  end

  // Stall whenever a request is pending in IDLE or an access is in flight.
  always_comb begin
    ready = ((state_q == StIdle) && !(rd_en || wr_en)) || (state_q == StDone);
  end

  assign read_data   = read_data_q;
  assign sram_addr   = sram_addr_q;
  assign sram_dq_out = dq_out_q;
  assign sram_dq_oe  = dq_oe_q;
  assign sram_we_n   = we_n_q;
  assign sram_oe_n   = oe_n_q;

endmodule
